// File: rtl/mem_stage.sv
// Memory stage: sequences scalar/vector loads and stores one element per cycle over
// the data-memory port, drives the registered writeback bus and stalls upstream while busy.
module mem_stage #(
    parameter int unsigned MEMO_LINES = 64,
    parameter int unsigned REGI_SIZE  = 16,
    parameter int unsigned VECT_SIZE  = 8,
    parameter int unsigned ELEM_SIZE  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [REGI_SIZE-1:0]            ialu_res_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0]  valu_res_i,
    input  logic [REGI_SIZE-1:0]            st_data_i,
    input  logic                            enableMem_i,
    input  logic                            enableReg_i,
    input  logic                            flagMemRead_i,
    input  logic                            flagMemWrite_i,
    input  logic                            isOper1V_i,
    input  logic                            writeResultInt_i,
    input  logic                            writeResultV_i,
    output logic                            stall_o,
    output logic [$clog2(MEMO_LINES)-1:0]   mem_addr_o,
    output logic                            mem_re_o,
    output logic                            mem_we_o,
    output logic [ELEM_SIZE-1:0]            mem_wdata_o,
    input  logic [ELEM_SIZE-1:0]            mem_rdata_i,
    output logic [REGI_SIZE-1:0]            wb_ialu_o,
    output logic [ELEM_SIZE*VECT_SIZE-1:0]  wb_valu_o,
    output logic                            wb_int_we_o,
    output logic                            wb_vec_we_o
);
    localparam int unsigned AW = $clog2(MEMO_LINES);
    localparam int unsigned VW = ELEM_SIZE * VECT_SIZE;
    localparam int unsigned NS = REGI_SIZE / ELEM_SIZE;
    localparam int unsigned NV = VECT_SIZE;
    localparam int unsigned BW = $clog2(NV + 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t        state;
    logic [BW-1:0] beat;
    logic [BW-1:0] beatsN;
    logic [AW-1:0] base;
    logic [VW-1:0] dataBuf;
    logic          isLoad;
    logic          isVec;
    logic          wbInt;
    logic          wbVec;

    logic          memOp;
    logic          vecOp;
    logic          lastBeat;
    logic [BW-1:0] prevBeat;
    logic [AW-1:0] beatAddr;

    assign memOp    = enableMem_i & (flagMemRead_i | flagMemWrite_i);
    assign vecOp    = flagMemRead_i ? writeResultV_i : isOper1V_i;
    assign lastBeat = (beat == beatsN - BW'(1));
    assign prevBeat = beat - BW'(1);
    assign beatAddr = base + AW'(beat);

    // Memory port and stall follow the current state; only IDLE looks at the inputs.
    always_comb begin
        stall_o     = 1'b0;
        mem_addr_o  = '0;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        case (state)
            IDLE:  stall_o = memOp;
            READ: begin
                stall_o    = 1'b1;
                mem_re_o   = 1'b1;
                mem_addr_o = beatAddr;
            end
            WAIT:  stall_o = 1'b1;
            WRITE: begin
                stall_o     = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = beatAddr;
                mem_wdata_o = dataBuf[32'(beat)*ELEM_SIZE +: ELEM_SIZE];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            beat        <= '0;
            beatsN      <= '0;
            base        <= '0;
            dataBuf     <= '0;
            isLoad      <= 1'b0;
            isVec       <= 1'b0;
            wbInt       <= 1'b0;
            wbVec       <= 1'b0;
            wb_ialu_o   <= '0;
            wb_valu_o   <= '0;
            wb_int_we_o <= 1'b0;
            wb_vec_we_o <= 1'b0;
        end else begin
            wb_int_we_o <= 1'b0;
            wb_vec_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (memOp) begin
                        base    <= ialu_res_i[AW-1:0];
                        isLoad  <= flagMemRead_i;
                        isVec   <= vecOp;
                        beatsN  <= vecOp ? BW'(NV) : BW'(NS);
                        dataBuf <= isOper1V_i ? valu_res_i : VW'(st_data_i);
                        wbInt   <= enableReg_i & writeResultInt_i;
                        wbVec   <= enableReg_i & writeResultV_i;
                        beat    <= '0;
                        state   <= flagMemRead_i ? READ : WRITE;
                    end else begin
                        wb_ialu_o   <= ialu_res_i;
                        wb_valu_o   <= valu_res_i;
                        wb_int_we_o <= enableReg_i & writeResultInt_i;
                        wb_vec_we_o <= enableReg_i & writeResultV_i;
                    end
                end
                // Read data trails its issue by one cycle, so each beat stores the previous one.
                READ: begin
                    if (beat != '0)
                        dataBuf[32'(prevBeat)*ELEM_SIZE +: ELEM_SIZE] <= mem_rdata_i;
                    beat <= beat + BW'(1);
                    if (lastBeat)
                        state <= WAIT;
                end
                WAIT: begin
                    dataBuf[32'(prevBeat)*ELEM_SIZE +: ELEM_SIZE] <= mem_rdata_i;
                    state <= DONE;
                end
                WRITE: begin
                    beat <= beat + BW'(1);
                    if (lastBeat)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    beat  <= '0;
                    if (isLoad) begin
                        if (isVec) begin
                            wb_valu_o   <= dataBuf;
                            wb_ialu_o   <= '0;
                            wb_vec_we_o <= wbVec;
                        end else begin
                            wb_ialu_o   <= dataBuf[REGI_SIZE-1:0];
                            wb_valu_o   <= '0;
                            wb_int_we_o <= wbInt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model predicts address sequences,
// store data, load results and strobe timing; a behavioural memory answers the port.
module tb_mem_stage;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] ialu_res_i;
    logic [63:0] valu_res_i;
    logic [15:0] st_data_i;
    logic        enableMem_i, enableReg_i, flagMemRead_i, flagMemWrite_i;
    logic        isOper1V_i, writeResultInt_i, writeResultV_i;
    logic        stall_o;
    logic [5:0]  mem_addr_o;
    logic        mem_re_o, mem_we_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;
    logic [15:0] wb_ialu_o;
    logic [63:0] wb_valu_o;
    logic        wb_int_we_o, wb_vec_we_o;

    always #5 clk_i = ~clk_i;

    mem_stage #(
        .MEMO_LINES(64), .REGI_SIZE(16), .VECT_SIZE(8), .ELEM_SIZE(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ialu_res_i(ialu_res_i), .valu_res_i(valu_res_i), .st_data_i(st_data_i),
        .enableMem_i(enableMem_i), .enableReg_i(enableReg_i),
        .flagMemRead_i(flagMemRead_i), .flagMemWrite_i(flagMemWrite_i),
        .isOper1V_i(isOper1V_i), .writeResultInt_i(writeResultInt_i),
        .writeResultV_i(writeResultV_i), .stall_o(stall_o),
        .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .wb_ialu_o(wb_ialu_o), .wb_valu_o(wb_valu_o),
        .wb_int_we_o(wb_int_we_o), .wb_vec_we_o(wb_vec_we_o)
    );

    typedef struct {
        logic        en, rg, rd, wr, op1v, wi, wv;
        logic [15:0] ialu, st;
        logic [63:0] valu;
    } opT;

    // Data memory seen by the DUT; refMem is the model's own view of it.
    logic [7:0] memArr [64];
    logic [7:0] refMem [64];
    logic       memLoad;

    always @(posedge clk_i) begin
        if (memLoad) begin
            for (int a = 0; a < 64; a++) memArr[a] <= 8'(a);
        end else begin
            if (mem_we_o) memArr[mem_addr_o] <= mem_wdata_o;
            if (mem_re_o) mem_rdata_i <= memArr[mem_addr_o];
        end
    end

    int          nChecks = 0;
    int          nFails  = 0;
    logic [15:0] lastIdleI;
    logic [63:0] lastIdleV;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyOp(input opT o);
        enableMem_i      = o.en;
        enableReg_i      = o.rg;
        flagMemRead_i    = o.rd;
        flagMemWrite_i   = o.wr;
        isOper1V_i       = o.op1v;
        writeResultInt_i = o.wi;
        writeResultV_i   = o.wv;
        ialu_res_i       = o.ialu;
        valu_res_i       = o.valu;
        st_data_i        = o.st;
    endtask

    function automatic opT randOp();
        opT o;
        o.en   = ($urandom_range(0, 7) != 0);
        o.rg   = 1'($urandom);
        o.rd   = 1'($urandom);
        o.wr   = 1'($urandom);
        o.op1v = 1'($urandom);
        o.wv   = 1'($urandom);
        o.wi   = o.rd ? ~o.wv : 1'($urandom);
        o.ialu = 16'($urandom);
        o.st   = 16'($urandom);
        o.valu = {$urandom, $urandom};
        return o;
    endfunction

    task automatic idleInputs();
        opT o;
        o = randOp();
        o.en = 1'b0;
        o.rg = 1'b0;
        applyOp(o);
        lastIdleI = o.ialu;
        lastIdleV = o.valu;
    endtask

    task automatic randomInputs();
        applyOp(randOp());
    endtask

    // Presents one op at a cycle boundary and checks every cycle until it has fully retired.
    task automatic runOp(input opT o, input bit hasFollow, input opT follow);
        logic        isMem, isLd, isV;
        int          n;
        logic [5:0]  base, a;
        logic [63:0] expData, src, heldV;
        logic [15:0] heldI;
        isMem   = o.en & (o.rd | o.wr);
        heldI   = lastIdleI;
        heldV   = lastIdleV;
        expData = '0;
        tick();
        applyOp(o);
        #1;
        if (!isMem) begin
            checkVal("pt_stall", 64'(stall_o), 64'd0);
            checkVal("pt_port", 64'({mem_re_o, mem_we_o}), 64'd0);
            tick();
            idleInputs();
            #1;
            checkVal("pt_ialu", 64'(wb_ialu_o), 64'(o.ialu));
            checkVal("pt_valu", wb_valu_o, o.valu);
            checkVal("pt_int_we", 64'(wb_int_we_o), 64'(o.rg & o.wi));
            checkVal("pt_vec_we", 64'(wb_vec_we_o), 64'(o.rg & o.wv));
        end else begin
            isLd = o.rd;
            isV  = isLd ? o.wv : o.op1v;
            n    = isV ? 8 : 2;
            base = o.ialu[5:0];
            src  = o.op1v ? o.valu : 64'(o.st);
            checkVal("acc_stall", 64'(stall_o), 64'd1);
            checkVal("acc_port", 64'({mem_re_o, mem_we_o}), 64'd0);
            for (int k = 0; k < n; k++) begin
                tick();
                randomInputs();
                #1;
                a = base + 6'(k);
                checkVal("beat_stall", 64'(stall_o), 64'd1);
                checkVal("beat_addr", 64'(mem_addr_o), 64'(a));
                if (isLd) begin
                    checkVal("beat_re", 64'({mem_re_o, mem_we_o}), 64'd2);
                    expData[k*8 +: 8] = refMem[a];
                end else begin
                    checkVal("beat_we", 64'({mem_re_o, mem_we_o}), 64'd1);
                    checkVal("beat_wdata", 64'(mem_wdata_o), 64'(src[k*8 +: 8]));
                    refMem[a] = src[k*8 +: 8];
                end
            end
            if (isLd) begin
                tick();
                randomInputs();
                #1;
                checkVal("wait_stall", 64'(stall_o), 64'd1);
                checkVal("wait_re", 64'(mem_re_o), 64'd0);
            end
            tick();
            randomInputs();
            #1;
            checkVal("done_stall", 64'(stall_o), 64'd0);
            checkVal("done_port", 64'({mem_re_o, mem_we_o}), 64'd0);
            tick();
            if (hasFollow) applyOp(follow);
            else idleInputs();
            #1;
            checkVal("post_stall", 64'(stall_o), 64'd0);
            if (isLd && isV) begin
                checkVal("vld_valu", wb_valu_o, expData);
                checkVal("vld_ialu", 64'(wb_ialu_o), 64'd0);
                checkVal("vld_vec_we", 64'(wb_vec_we_o), 64'(o.rg));
                checkVal("vld_int_we", 64'(wb_int_we_o), 64'd0);
            end else if (isLd) begin
                checkVal("sld_ialu", 64'(wb_ialu_o), 64'(expData[15:0]));
                checkVal("sld_valu", wb_valu_o, 64'd0);
                checkVal("sld_int_we", 64'(wb_int_we_o), 64'(o.rg & o.wi));
                checkVal("sld_vec_we", 64'(wb_vec_we_o), 64'd0);
            end else begin
                checkVal("st_hold_ialu", 64'(wb_ialu_o), 64'(heldI));
                checkVal("st_hold_valu", wb_valu_o, heldV);
                checkVal("st_no_strobe", 64'({wb_int_we_o, wb_vec_we_o}), 64'd0);
            end
            if (hasFollow) begin
                tick();
                idleInputs();
                #1;
                checkVal("fol_ialu", 64'(wb_ialu_o), 64'(follow.ialu));
                checkVal("fol_int_we", 64'(wb_int_we_o), 64'(follow.rg & follow.wi));
                checkVal("fol_vec_we", 64'(wb_vec_we_o), 64'(follow.rg & follow.wv));
            end
        end
        tick();
        idleInputs();
        #1;
        checkVal("we_clear", 64'({wb_int_we_o, wb_vec_we_o}), 64'd0);
    endtask

    initial begin
        opT o, z, f;
        z = '{default: '0};
        for (int a = 0; a < 64; a++) refMem[a] = 8'(a);
        rst_i   = 1'b0;
        memLoad = 1'b1;
        idleInputs();
        repeat (2) begin
            tick();
            idleInputs();
            #1;
        end
        checkVal("rst_ialu", 64'(wb_ialu_o), 64'd0);
        checkVal("rst_valu", wb_valu_o, 64'd0);
        checkVal("rst_we", 64'({wb_int_we_o, wb_vec_we_o}), 64'd0);
        checkVal("rst_port", 64'({stall_o, mem_re_o, mem_we_o}), 64'd0);
        tick();
        rst_i   = 1'b1;
        memLoad = 1'b0;
        idleInputs();
        #1;

        // Non-mem pass-through
        o = z; o.rg = 1'b1; o.wi = 1'b1; o.ialu = 16'hBEEF;
        runOp(o, 1'b0, z);
        // Vector load wrapping the top of memory
        o = z; o.en = 1'b1; o.rd = 1'b1; o.wv = 1'b1; o.rg = 1'b1; o.ialu = 16'h003C;
        runOp(o, 1'b0, z);
        // Scalar store
        o = z; o.en = 1'b1; o.wr = 1'b1; o.ialu = 16'h0010; o.st = 16'hA55A; o.rg = 1'b1; o.wi = 1'b1;
        runOp(o, 1'b0, z);
        // Vector store wrapping, then read it back
        o = z; o.en = 1'b1; o.wr = 1'b1; o.op1v = 1'b1; o.ialu = 16'h003F; o.valu = 64'h0807060504030201;
        runOp(o, 1'b0, z);
        o = z; o.en = 1'b1; o.rd = 1'b1; o.wv = 1'b1; o.rg = 1'b1; o.ialu = 16'hFF3F;
        runOp(o, 1'b0, z);
        // Scalar load read back of the scalar store
        o = z; o.en = 1'b1; o.rd = 1'b1; o.wi = 1'b1; o.rg = 1'b1; o.ialu = 16'h0010;
        runOp(o, 1'b0, z);

        // Reset during READ beat 3 of a vector load aborts with no strobe
        o = z; o.en = 1'b1; o.rd = 1'b1; o.wv = 1'b1; o.rg = 1'b1; o.ialu = 16'h0008;
        tick();
        applyOp(o);
        #1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            randomInputs();
            if (k == 4) rst_i = 1'b0;
            #1;
            if (k == 4) checkVal("rst_beat3_addr", 64'(mem_addr_o), 64'h0B);
        end
        tick();
        rst_i = 1'b1;
        idleInputs();
        #1;
        checkVal("abort_re", 64'(mem_re_o), 64'd0);
        checkVal("abort_stall", 64'(stall_o), 64'd0);
        checkVal("abort_ialu", 64'(wb_ialu_o), 64'd0);
        checkVal("abort_valu", wb_valu_o, 64'd0);
        checkVal("abort_we", 64'({wb_int_we_o, wb_vec_we_o}), 64'd0);
        repeat (12) begin
            tick();
            idleInputs();
            #1;
            checkVal("abort_no_strobe", 64'({wb_int_we_o, wb_vec_we_o, mem_re_o}), 64'd0);
        end

        // Scalar load followed by a non-mem op presented once upstream advances
        o = z; o.en = 1'b1; o.rd = 1'b1; o.wi = 1'b1; o.rg = 1'b1; o.ialu = 16'h0020;
        f = z; f.rg = 1'b1; f.wi = 1'b1; f.ialu = 16'h1234; f.valu = {$urandom, $urandom};
        runOp(o, 1'b1, f);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            o = randOp();
            f = randOp();
            f.en = 1'b0;
            runOp(o, ($urandom_range(0, 3) == 0), f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule
